// File: rtl/secded_pkg.sv
// Shared definitions for the SECDED stream codec: status codes and the
// constant functions that describe the Hamming bit layout.
package secded_pkg;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'b00,
      ST_CORR   = 2'b01,
      ST_DED    = 2'b10,
      ST_BADSYN = 2'b11
   } status_e;

   // Widest payload the parity masks can describe.
   localparam int MAX_DATA_W = 64;

   // Smallest r with 2^r >= data_w + r + 1.
   function automatic int calc_par_w(input int data_w);
      int r;
      r = 0;
      for (int k = 1; k < 16; k++) begin
         if (r == 0 && (1 << k) >= data_w + k + 1) r = k;
      end
      return r;
   endfunction

   // Hamming position of data bit i: the (i+1)-th non-power-of-two position.
   function automatic int data_pos(input int i);
      int pos;
      int cnt;
      pos = 0;
      cnt = 0;
      for (int p = 3; p < i + 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == i && pos == 0) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

   // Data bits covered by parity bit j (position has bit j set).
   function automatic logic [MAX_DATA_W-1:0] par_mask(input int data_w, input int j);
      logic [MAX_DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < data_w; i++) begin
         if (((data_pos(i) >> j) & 1) == 1) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/secded_parity_gen.sv
// Combinational Hamming parity over the payload; shared by encode and
// syndrome paths.
module secded_parity_gen
   import secded_pkg::*;
#(
   parameter int DATA_W = 11,
   parameter int PAR_W  = calc_par_w(DATA_W)
) (
   input  logic [DATA_W-1:0] data_i,
   output logic [PAR_W-1:0]  par_o
);

   for (genvar j = 0; j < PAR_W; j++) begin : g_par
      localparam logic [MAX_DATA_W-1:0] MASK = par_mask(DATA_W, j);
      assign par_o[j] = ^(data_i & MASK[DATA_W-1:0]);
   end

endmodule

// File: rtl/secded_stream_codec.sv
// Two-stage pipelined SECDED encoder/decoder with valid/ready on both sides
// and saturating error counters.
module secded_stream_codec
   import secded_pkg::*;
#(
   parameter  int DATA_W = 11,
   parameter  int CNT_W  = 16,
   localparam int PAR_W  = calc_par_w(DATA_W),
   localparam int CODE_W = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [CODE_W-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_word,
   output logic [1:0]        out_status,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_uncorr
);

   logic              s1_valid_q, s1_mode_q, s1_g_q, s1_g_d;
   logic [CODE_W-1:0] s1_word_q, s1_word_d;
   logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s2_valid_q;
   logic [CODE_W-1:0] s2_word_q, s2_word_d;
   logic [1:0]        s2_st_q, s2_st_d;
   logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;
   logic [PAR_W-1:0]  par;
   logic [CODE_W-1:0] flip_vec;
   logic              s1_adv, out_hs;

   assign s1_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign out_hs   = s2_valid_q && out_ready;

   secded_parity_gen #(.DATA_W(DATA_W), .PAR_W(PAR_W)) u_par (
      .data_i (in_word[DATA_W-1:0]),
      .par_o  (par)
   );

   // One-hot flip pattern for the current syndrome; all-zero when the
   // syndrome points past the last Hamming position.
   for (genvar i = 0; i < DATA_W; i++) begin : g_flip_d
      localparam int DPOS = data_pos(i);
      assign flip_vec[i] = (s1_syn_q == PAR_W'(DPOS));
   end
   for (genvar j = 0; j < PAR_W; j++) begin : g_flip_p
      assign flip_vec[DATA_W+j] = (s1_syn_q == PAR_W'(1 << j));
   end
   assign flip_vec[CODE_W-1] = (s1_syn_q == '0);

   // Stage-1 capture: build the codeword for encode, syndrome and g for decode.
   always_comb begin
      s1_syn_d = par ^ in_word[DATA_W+PAR_W-1:DATA_W];
      s1_g_d   = ^in_word;
      if (in_mode) s1_word_d = in_word;
      else         s1_word_d = {^{par, in_word[DATA_W-1:0]}, par, in_word[DATA_W-1:0]};
   end

   // Stage-2 result: correct the word and classify the error.
   always_comb begin
      s2_word_d = s1_word_q;
      s2_st_d   = ST_CLEAN;
      if (s1_mode_q) begin
         if (s1_g_q) begin
            if (|flip_vec) begin
               s2_word_d = s1_word_q ^ flip_vec;
               s2_st_d   = ST_CORR;
            end else begin
               s2_st_d   = ST_BADSYN;
            end
         end else if (s1_syn_q != '0) begin
            s2_st_d = ST_DED;
         end
      end
   end

   // Saturating counters; a clear overrides any increment in the same cycle.
   always_comb begin
      cnt_corr_d   = cnt_corr_q;
      cnt_uncorr_d = cnt_uncorr_q;
      if (cnt_clr) begin
         cnt_corr_d   = '0;
         cnt_uncorr_d = '0;
      end else if (out_hs) begin
         if (s2_st_q == ST_CORR && cnt_corr_q != '1)
            cnt_corr_d = cnt_corr_q + 1'b1;
         if (s2_st_q[1] && cnt_uncorr_q != '1)
            cnt_uncorr_d = cnt_uncorr_q + 1'b1;
      end
   end

   // Stage-1 register: loads whenever it is empty or draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_word_q  <= '0;
         s1_syn_q   <= '0;
         s1_g_q     <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_mode_q <= in_mode;
            s1_word_q <= s1_word_d;
            s1_syn_q  <= s1_syn_d;
            s1_g_q    <= s1_g_d;
         end
      end
   end

   // Stage-2 register: payload held stable while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_word_q  <= '0;
         s2_st_q    <= ST_CLEAN;
      end else if (s1_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_word_q <= s2_word_d;
            s2_st_q   <= s2_st_d;
         end
      end
   end

   // Error counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_corr_q   <= '0;
         cnt_uncorr_q <= '0;
      end else begin
         cnt_corr_q   <= cnt_corr_d;
         cnt_uncorr_q <= cnt_uncorr_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_word   = s2_word_q;
   assign out_status = s2_st_q;
   assign cnt_corr   = cnt_corr_q;
   assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_secded_stream_codec.sv
// Bench for secded_stream_codec: default instance (11-bit payload) with a
// scoreboard, plus a DATA_W=8 / CNT_W=2 instance for bad-syndrome and
// saturation cases.
module tb_secded_stream_codec;

   localparam int DW = 11;
   localparam int PW = 4;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default instance
   logic          in_valid, in_ready, in_mode, out_valid, out_ready, cnt_clr;
   logic [CW-1:0] in_word, out_word;
   logic [1:0]    out_status;
   logic [15:0]   cnt_corr, cnt_uncorr;

   // small instance
   logic        s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_cnt_clr;
   logic [12:0] s_in_word, s_out_word;
   logic [1:0]  s_out_status;
   logic [1:0]  s_cnt_corr, s_cnt_uncorr;

   secded_stream_codec #(.DATA_W(DW), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_status(out_status),
      .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
   );

   secded_stream_codec #(.DATA_W(8), .CNT_W(2)) u_small (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_mode(s_in_mode), .in_word(s_in_word),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_word(s_out_word), .out_status(s_out_status),
      .cnt_clr(s_cnt_clr), .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: builds the Hamming position vector explicitly and
   // derives the syndrome as the XOR of positions holding a one.
   function automatic logic [17:0] ref_model(input logic mode, input logic [15:0] w);
      int          dp[DW];
      int          k, s;
      logic [15:0] code, res;
      logic        pb, g;
      logic [1:0]  st;
      k = 0;
      for (int p = 1; p < 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            dp[k] = p;
            k++;
         end
      end
      code = '0;
      for (int i = 0; i < DW; i++) code[dp[i]] = w[i];
      if (!mode) begin
         for (int j = 0; j < PW; j++) begin
            pb = 1'b0;
            for (int p = 1; p < 16; p++) if (((p >> j) & 1) == 1) pb = pb ^ code[p];
            code[1 << j] = pb;
         end
         g   = ^code;
         res = {g, code[8], code[4], code[2], code[1], w[DW-1:0]};
         return {2'b00, res};
      end
      for (int j = 0; j < PW; j++) code[1 << j] = w[DW+j];
      s = 0;
      for (int p = 1; p < 16; p++) if (code[p]) s = s ^ p;
      g   = ^w;
      res = w;
      if (!g && s == 0) st = 2'b00;
      else if (g && s == 0) begin
         res[15] = ~res[15];
         st = 2'b01;
      end else if (g) begin
         st = 2'b01;
         for (int j = 0; j < PW; j++) if (s == (1 << j)) res[DW+j] = ~res[DW+j];
         for (int i = 0; i < DW; i++) if (s == dp[i]) res[i] = ~res[i];
      end else st = 2'b10;
      return {st, res};
   endfunction

   // scoreboard
   logic [17:0] exp_q[$];
   logic [17:0] e;
   logic [17:0] held;
   logic        held_v = 1'b0;
   int          mc = 0;
   int          mu = 0;

   // Monitor: compares delivered words in order and checks output stability while stalled.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("out_word", {16'h0, out_word}, {16'h0, e[15:0]});
            chk("out_status", {30'h0, out_status}, {30'h0, e[17:16]});
            if (e[17:16] == 2'b01) mc++;
            if (e[17]) mu++;
         end
      end
      if (held_v && out_valid) chk("hold_stable", {14'h0, out_status, out_word}, {14'h0, held});
      held_v = out_valid && !out_ready;
      held   = {out_status, out_word};
   end

   logic toggle_en = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) out_ready = ~out_ready;
      end
   end

   // Drive one word; caller sits just after a rising edge.
   task automatic send(input logic m, input logic [15:0] w, input logic [17:0] exp);
      int t;
      bit ok;
      in_valid = 1'b1;
      in_mode  = m;
      in_word  = w;
      exp_q.push_back(exp);
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 100) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         t++;
      end
      if (!ok) chk("in_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Single transfer on the small instance with a direct check.
   task automatic small_xfer(input logic [12:0] w, input logic [12:0] ew, input logic [1:0] est);
      int t;
      s_in_valid = 1'b1;
      s_in_mode  = 1'b1;
      s_in_word  = w;
      @(negedge clk);
      chk("s_in_ready", {31'h0, s_in_ready}, 1);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!s_out_valid && t < 8) begin
         @(negedge clk);
         t++;
      end
      chk("s_out_valid", {31'h0, s_out_valid}, 1);
      chk("s_out_word", {19'h0, s_out_word}, {19'h0, ew});
      chk("s_out_status", {30'h0, s_out_status}, {30'h0, est});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        m;
      logic [10:0] d;
      logic [15:0] w, base;
      logic [17:0] tmp;
      int          nf, t;
      bit          seen;

      rst_n = 1'b0;
      in_valid = 1'b0; in_mode = 1'b0; in_word = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      s_in_valid = 1'b0; s_in_mode = 1'b1; s_in_word = '0; s_out_ready = 1'b1; s_cnt_clr = 1'b0;
      #12;
      chk("rst_in_ready", {31'h0, in_ready}, 1);
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_out_word", {16'h0, out_word}, 0);
      chk("rst_out_status", {30'h0, out_status}, 0);
      chk("rst_cnt", {cnt_corr, cnt_uncorr}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // latency: encode 11'h001
      in_valid = 1'b1; in_mode = 1'b0; in_word = 16'h0001;
      exp_q.push_back({2'b00, 16'h9801});
      @(negedge clk);
      chk("lat_in_ready", {31'h0, in_ready}, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1", {31'h0, out_valid}, 0);
      @(negedge clk);
      chk("lat_cycle2", {31'h0, out_valid}, 1);
      chk("enc_001", {16'h0, out_word}, 32'h9801);
      @(posedge clk);
      #1;

      // directed vectors from the plan
      send(1'b0, 16'h0000, {2'b00, 16'h0000});
      send(1'b1, 16'h9800, {2'b01, 16'h9801});
      send(1'b1, 16'h9802, {2'b10, 16'h9802});
      send(1'b1, 16'h1801, {2'b01, 16'h9801});
      drain();
      chk("cnt_corr_dir", {16'h0, cnt_corr}, 2);
      chk("cnt_uncorr_dir", {16'h0, cnt_uncorr}, 1);

      // mixed stream with out_ready toggling
      toggle_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         m = 1'($urandom_range(0, 1));
         d = 11'($urandom);
         if (!m) begin
            w = {5'($urandom), d};
         end else begin
            tmp  = ref_model(1'b0, {5'h0, d});
            base = tmp[15:0];
            nf   = $urandom_range(0, 2);
            w    = base;
            for (int f = 0; f < nf; f++) w[$urandom_range(0, 15)] ^= 1'b1;
         end
         send(m, w, ref_model(m, w));
      end
      drain();
      toggle_en = 1'b0;
      #2;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("cnt_corr_model", {16'h0, cnt_corr}, mc);
      chk("cnt_uncorr_model", {16'h0, cnt_uncorr}, mu);

      // clear coinciding with a corrected handshake
      out_ready = 1'b0;
      send(1'b1, 16'h9800, {2'b01, 16'h9801});
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("clr_out_valid", {31'h0, out_valid}, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      mc = 0;
      mu = 0;
      chk("clr_wins_corr", {16'h0, cnt_corr}, 0);
      chk("clr_wins_uncorr", {16'h0, cnt_uncorr}, 0);

      // reset with two words in flight
      send(1'b0, 16'h0123, ref_model(1'b0, 16'h0123));
      send(1'b1, 16'h9800, {2'b01, 16'h9801});
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", {31'h0, out_valid}, 0);
      exp_q.delete();
      mc = 0;
      mu = 0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("no_out_after_rst", {31'h0, seen}, 0);
      chk("rst_mid_cnt", {cnt_corr, cnt_uncorr}, 0);
      @(posedge clk);
      #1;

      // DATA_W=8: s=13 with g=1 is an invalid syndrome
      small_xfer(13'h0D00, 13'h0D00, 2'b11);
      chk("s_cnt_uncorr", {30'h0, s_cnt_uncorr}, 1);
      chk("s_cnt_corr0", {30'h0, s_cnt_corr}, 0);

      // CNT_W=2 saturation with five corrected words
      for (int k = 0; k < 3; k++) small_xfer(13'h1000, 13'h0000, 2'b01);
      chk("s_cnt_corr3", {30'h0, s_cnt_corr}, 3);
      for (int k = 0; k < 2; k++) small_xfer(13'h1000, 13'h0000, 2'b01);
      chk("s_cnt_corr_sat", {30'h0, s_cnt_corr}, 3);
      chk("s_cnt_uncorr_keep", {30'h0, s_cnt_uncorr}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
